// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and defaults for the two-requester APB master arbiter.
package apb_master_arbiter_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Wait-counter width; a disabled timeout still needs one bit to keep the counter legal.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// Two-way round-robin arbiter: combinational grant, last_grant register updated on enable.
module rr_arbiter_2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic grant,
  output logic valid
);

  logic last_grant_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    valid = req0 | req1;
    grant = (req0 && req1) ? ~last_grant_q : req1;
  end

  // Reset to 1 so requester 0 wins the first tie.
  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               last_grant_q <= 1'b1;
    else if (update && valid) last_grant_q <= grant;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing, timeout abort.
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              write0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  input  logic              req1,
  input  logic              write1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int             CNT_W   = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d, wait_inc;
  logic             gnt_q;
  logic             arb_grant, arb_valid;
  logic             timeout_hit;
  logic             grant_now;

  assign grant_now = (state_q == IDLE) && arb_valid;

  rr_arbiter_2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .req1   (req1),
    .update (state_q == IDLE),
    .grant  (arb_grant),
    .valid  (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    timeout_hit = 1'b0;
    wait_inc    = (wait_q == CNT_MAX) ? wait_q : wait_q + 1'b1;
    unique case (state_q)
      IDLE: if (arb_valid) begin
        state_d = SETUP;
        wait_d  = '0;
      end
      SETUP: state_d = ACCESS;
      // With TIMEOUT=0 the limit is 0, which a saturating increment from 0 never hits.
      ACCESS: if (pready) begin
        state_d = DONE;
      end else begin
        wait_d = wait_inc;
        if (wait_inc == CNT_LIM) begin
          state_d     = DONE;
          timeout_hit = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      gnt_q   <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      psel    <= (state_d == SETUP) || (state_d == ACCESS);
      penable <= (state_d == ACCESS);
      done0   <= (state_d == DONE) && !gnt_q;
      done1   <= (state_d == DONE) &&  gnt_q;
      rdata   <= (state_d == DONE && !timeout_hit && !pwrite) ? prdata : '0;
      err     <= (state_d == DONE) && (timeout_hit || pslverr);
      if (grant_now) begin
        gnt_q  <= arb_grant;
        pwrite <= arb_grant ? write1 : write0;
        paddr  <= arb_grant ? addr1  : addr0;
        pwdata <= arb_grant ? wdata1 : wdata0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench: vector table of single transfers plus tie, timeout and reset sequences.
module tb_apb_master_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0 = 1'b0, write0 = 1'b0, req1 = 1'b0, write1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              done0, done1, err, psel, penable, pwrite;
  logic [DATA_W-1:0] rdata, pwdata;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] prdata = '0;
  logic              pready = 1'b1, pslverr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apb_master_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .write0(write0), .addr0(addr0), .wdata0(wdata0), .done0(done0),
    .req1(req1), .write1(write1), .addr1(addr1), .wdata1(wdata1), .done1(done1),
    .rdata(rdata), .err(err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic              sel;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one zero-wait transfer already requested by `who`; winner drops req on done.
  task automatic do_txn(input int who, input logic [ADDR_W-1:0] exp_addr, input logic exp_write,
                        input logic [DATA_W-1:0] exp_wdata, input logic [DATA_W-1:0] exp_rdata,
                        input logic exp_err, input bit reraise, input string tag);
    logic [ADDR_W-1:0] sv_addr;
    logic [DATA_W-1:0] sv_wdata;
    step();
    check({tag, " setup psel"},    32'(psel), 32'd1);
    check({tag, " setup penable"}, 32'(penable), 32'd0);
    check({tag, " setup paddr"},   32'(paddr), 32'(exp_addr));
    check({tag, " setup pwrite"},  32'(pwrite), 32'(exp_write));
    check({tag, " setup pwdata"},  pwdata, exp_wdata);
    check({tag, " setup done"},    32'(done0 | done1), 32'd0);
    // Winner's inputs change after the grant; APB outputs must not follow.
    sv_addr  = (who == 0) ? addr0 : addr1;
    sv_wdata = (who == 0) ? wdata0 : wdata1;
    if (who == 0) begin addr0 = ~addr0; wdata0 = ~wdata0; end
    else          begin addr1 = ~addr1; wdata1 = ~wdata1; end
    step();
    check({tag, " access psel"},    32'(psel), 32'd1);
    check({tag, " access penable"}, 32'(penable), 32'd1);
    check({tag, " access paddr"},   32'(paddr), 32'(exp_addr));
    check({tag, " access pwdata"},  pwdata, exp_wdata);
    step();
    check({tag, " done winner"}, 32'((who == 0) ? done0 : done1), 32'd1);
    check({tag, " done other"},  32'((who == 0) ? done1 : done0), 32'd0);
    check({tag, " rdata"},       rdata, exp_rdata);
    check({tag, " err"},         32'(err), 32'(exp_err));
    check({tag, " done psel"},   32'(psel | penable), 32'd0);
    if (who == 0) begin req0 = 1'b0; addr0 = sv_addr; wdata0 = sv_wdata; end
    else          begin req1 = 1'b0; addr1 = sv_addr; wdata1 = sv_wdata; end
    step();
    check({tag, " idle done"},  32'(done0 | done1), 32'd0);
    check({tag, " idle err"},   32'(err), 32'd0);
    check({tag, " idle rdata"}, rdata, 32'd0);
    if (reraise) begin
      if (who == 0) req0 = 1'b1;
      else          req1 = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncyc;
    vecs[0] = '{1'b0, 1'b1, 12'h004, 32'hA5A5_0001, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 12'h010, 32'h0000_0000, 32'h0000_00FF, 1'b0, 32'h0000_00FF, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 12'h7FF, 32'h0000_0042, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 12'h020, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 32'h0000_0000, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 12'hFFC, 32'h0000_0007, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b0};

    // Reset state
    #1;
    check("reset psel",    32'(psel), 32'd0);
    check("reset penable", 32'(penable), 32'd0);
    check("reset pwrite",  32'(pwrite), 32'd0);
    check("reset paddr",   32'(paddr), 32'd0);
    check("reset pwdata",  pwdata, 32'd0);
    check("reset done",    32'(done0 | done1), 32'd0);
    check("reset rdata",   rdata, 32'd0);
    check("reset err",     32'(err), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Tie right after reset: 0 first, then both keep requesting -> 1, 0, 1
    write0 = 1'b1; addr0 = 12'h100; wdata0 = 32'h1111_0000;
    write1 = 1'b0; addr1 = 12'h200; wdata1 = 32'h3333_0000;
    prdata = 32'h0000_2222; pready = 1'b1; pslverr = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    do_txn(0, 12'h100, 1'b1, 32'h1111_0000, 32'h0, 1'b0, 1'b1, "tie#1");
    do_txn(1, 12'h200, 1'b0, 32'h3333_0000, 32'h2222, 1'b0, 1'b1, "tie#2");
    do_txn(0, 12'h100, 1'b1, 32'h1111_0000, 32'h0, 1'b0, 1'b0, "tie#3");
    do_txn(1, 12'h200, 1'b0, 32'h3333_0000, 32'h2222, 1'b0, 1'b0, "tie#4");

    // Single-requester vectors
    for (int i = 0; i < 5; i++) begin
      prdata  = vecs[i].prdata;
      pslverr = vecs[i].pslverr;
      pready  = 1'b1;
      if (vecs[i].sel == 1'b0) begin
        write0 = vecs[i].write; addr0 = vecs[i].addr; wdata0 = vecs[i].wdata; req0 = 1'b1;
      end else begin
        write1 = vecs[i].write; addr1 = vecs[i].addr; wdata1 = vecs[i].wdata; req1 = 1'b1;
      end
      do_txn(vecs[i].sel ? 1 : 0, vecs[i].addr, vecs[i].write, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, 1'b0, $sformatf("vec%0d", i));
    end
    pslverr = 1'b0;

    // Timeout: pready held low
    write0 = 1'b0; addr0 = 12'h030; prdata = 32'h0000_DEAD; pready = 1'b0;
    req0 = 1'b1;
    step();
    check("to setup psel", 32'(psel), 32'd1);
    step();
    check("to access penable", 32'(penable), 32'd1);
    ncyc = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!penable) break;
      ncyc++;
    end
    check("to access cycles", 32'(ncyc), 32'd16);
    check("to done0", 32'(done0), 32'd1);
    check("to done1", 32'(done1), 32'd0);
    check("to err",   32'(err), 32'd1);
    check("to rdata", rdata, 32'd0);
    check("to psel",  32'(psel), 32'd0);
    req0 = 1'b0; pready = 1'b1;
    step();
    check("to idle done0", 32'(done0), 32'd0);
    check("to idle err",   32'(err), 32'd0);

    // Asynchronous reset in the middle of ACCESS
    write0 = 1'b1; addr0 = 12'h044; wdata0 = 32'h0BAD_0044; pready = 1'b0;
    req0 = 1'b1;
    step();
    step();
    check("rst pre penable", 32'(penable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst psel",    32'(psel), 32'd0);
    check("rst penable", 32'(penable), 32'd0);
    check("rst paddr",   32'(paddr), 32'd0);
    check("rst pwdata",  pwdata, 32'd0);
    check("rst pwrite",  32'(pwrite), 32'd0);
    req0 = 1'b0; pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst no done", 32'(done0 | done1), 32'd0);
    end
    rst_n = 1'b1;
    step();
    check("post-rst idle psel", 32'(psel), 32'd0);

    // After reset requester 0 again wins a tie, then requester 1 follows
    write0 = 1'b1; addr0 = 12'h0A0; wdata0 = 32'h5555_AAAA;
    write1 = 1'b0; addr1 = 12'h0B0; prdata = 32'h0000_0BB0;
    req0 = 1'b1; req1 = 1'b1;
    do_txn(0, 12'h0A0, 1'b1, 32'h5555_AAAA, 32'h0, 1'b0, 1'b0, "rst-tie#1");
    do_txn(1, 12'h0B0, 1'b0, wdata1, 32'h0000_0BB0, 1'b0, 1'b0, "rst-tie#2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
